sram_fill_writer: RTL and testbench

- Write-side controller for the banked four-way-read / one-way-write SRAM (256 entries x 72 bits, bank = addr%8).
- Accepts a valid/ready stream of 72-bit words and writes them to consecutive addresses from a programmed base, wrapping at 256.
- The SRAM cannot read and write in the same cycle, so this block also arbitrates: the read side has priority, and any read delay is bounded to one cycle.

---
 rtl/sram_pkg.sv | 14 +
 rtl/fill_arbiter.sv | 21 ++
 rtl/sram_fill_writer.sv | 102 ++++++++++
 tb/tb_sram_fill_writer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the banked 4-read/1-write SRAM and its
// fill-side writer. Bank of an entry is addr % SRAM_BANKS.
package sram_pkg;
    localparam int SRAM_ADDR_W = 8;
    localparam int SRAM_DATA_W = 72;
    localparam int SRAM_DEPTH  = 256;
    localparam int SRAM_BANKS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;
endpackage

// File: rtl/fill_arbiter.sv
// Combinational handshake / SRAM port arbitration for the fill writer.
//   fill_active : writer is in FILL
//   rem_nz      : words still owed in the current job
//   rd_req      : read side wants the SRAM this cycle
//   write_en    : a write is on the SRAM this cycle
//   ready       : writer may accept an input word
//   rd_grant    : read may use the SRAM this cycle
// Reads win over new writes; a read is only ever held off by the one write
// already in flight, and since ready is low while rd_req is high no second
// write can follow it.
module fill_arbiter (
    input  logic fill_active,
    input  logic rem_nz,
    input  logic rd_req,
    input  logic write_en,
    output logic ready,
    output logic rd_grant
);
    assign ready    = fill_active && rem_nz && !rd_req;
    assign rd_grant = rd_req && !write_en;
endmodule

// File: rtl/sram_fill_writer.sv
// Write-side controller for the banked SRAM. Streams valid/ready words into
// consecutive addresses starting at a programmed base (wrapping at DEPTH),
// one-cycle write latency, and arbitrates the shared SRAM port with reads.
// Ports:
//   i_fire, rst            clock (rising), async active-low reset
//   i_start, i_baseAddr,
//   i_count                job start (IDLE only), base address, word count
//   i_valid, i_data,
//   o_ready                input word stream
//   i_rd_req, o_rd_grant   read-side request / grant
//   o_write_en, o_writeAddr,
//   o_writeData            SRAM write port
//   o_busy, o_done,
//   o_filled               job status
module sram_fill_writer
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = SRAM_DEPTH
) (
    input  logic              i_fire,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_baseAddr,
    input  logic [ADDR_W:0]   i_count,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_rd_req,
    output logic              o_rd_grant,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_writeAddr,
    output logic [DATA_W-1:0] o_writeData,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_filled
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W:0]   count_clamped;
    logic              xfer;
    logic              job_start;

    assign count_clamped = (i_count > DEPTH_C) ? DEPTH_C : i_count;
    assign job_start     = (state_q == IDLE) && i_start;
    assign xfer          = i_valid && o_ready;
    assign o_busy        = (state_q == FILL);
    assign o_done        = (state_q == DONE);

    fill_arbiter u_arb (
        .fill_active (state_q == FILL),
        .rem_nz      (rem != '0),
        .rd_req      (i_rd_req),
        .write_en    (o_write_en),
        .ready       (o_ready),
        .rd_grant    (o_rd_grant)
    );

    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = (count_clamped == '0) ? DONE : FILL;
            // last word accepted: its write lands in the DONE cycle
            FILL: if (xfer && rem == (ADDR_W+1)'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            rem         <= '0;
            o_filled    <= '0;
            o_write_en  <= 1'b0;
            o_writeAddr <= '0;
            o_writeData <= '0;
        end else begin
            o_write_en <= xfer;
            if (job_start) begin
                ptr      <= i_baseAddr;
                rem      <= count_clamped;
                o_filled <= '0;
            end else if (xfer) begin
                o_writeAddr <= ptr;
                o_writeData <= i_data;
                ptr         <= ptr + 1'b1;
                rem         <= rem - 1'b1;
                o_filled    <= o_filled + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_fill_writer.sv
module tb_sram_fill_writer;
    logic        i_fire = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_baseAddr;
    logic [8:0]  i_count;
    logic        i_valid;
    logic [71:0] i_data;
    logic        o_ready;
    logic        i_rd_req;
    logic        o_rd_grant;
    logic        o_write_en;
    logic [7:0]  o_writeAddr;
    logic [71:0] o_writeData;
    logic        o_busy;
    logic        o_done;
    logic [8:0]  o_filled;

    int checks = 0;
    int errors = 0;
    logic [7:0] wr_log[$];

    sram_fill_writer dut (
        .i_fire(i_fire), .rst(rst), .i_start(i_start), .i_baseAddr(i_baseAddr),
        .i_count(i_count), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .i_rd_req(i_rd_req), .o_rd_grant(o_rd_grant), .o_write_en(o_write_en),
        .o_writeAddr(o_writeAddr), .o_writeData(o_writeData), .o_busy(o_busy),
        .o_done(o_done), .o_filled(o_filled)
    );

    always #5 i_fire = ~i_fire;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] rnd_word();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // Reference: a job writes min(cnt,256) words, in acceptance order, to
    // base, base+1, ... mod 256; each write shows up one cycle after its
    // acceptance; done is the cycle after the final acceptance.
    // vmode: 0 valid always, 1 alternating, 2 random
    // rmode: 0 no reads, 1 read burst on cycles 2-3, 2 random reads
    task automatic run_job(input logic [7:0] base, input logic [8:0] cnt,
                           input int vmode, input int rmode, input bit poke);
        int n;
        int acc = 0;
        int cyc = 0;
        logic [7:0]  mptr = base;
        logic [7:0]  paddr = 8'h0;
        logic [71:0] pdata = 72'h0;
        bit pend = 0, fin = 0, xfer, exp_ready, prev_denied = 0;
        n = (cnt > 9'd256) ? 256 : int'(cnt);
        wr_log.delete();
        i_start = 1'b1; i_baseAddr = base; i_count = cnt; i_valid = 1'b0; i_rd_req = 1'b0;
        @(posedge i_fire); #1;
        i_start = 1'b0;
        if (n == 0) fin = 1;
        forever begin
            i_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            i_rd_req = (rmode == 0) ? 1'b0 : (rmode == 1) ? (cyc == 2 || cyc == 3)
                                                          : ($urandom_range(0, 3) == 0);
            i_data   = rnd_word();
            i_start  = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                i_baseAddr = 8'($urandom);
                i_count    = 9'd1;
            end
            @(negedge i_fire);
            exp_ready = (acc < n) && !i_rd_req;
            check("ready", o_ready, exp_ready);
            check("busy", o_busy, !fin);
            check("done", o_done, fin);
            check("write_en", o_write_en, pend);
            check("rd_grant", o_rd_grant, i_rd_req && !pend);
            if (i_rd_req) check("read_wait", prev_denied && !o_rd_grant, 1'b0);
            prev_denied = i_rd_req && !o_rd_grant;
            if (rmode == 1 && cyc == 2) check("contention_deny", o_rd_grant, 1'b0);
            if (rmode == 1 && cyc == 3) check("contention_grant", o_rd_grant, 1'b1);
            if (pend) begin
                check("write_addr", o_writeAddr, paddr);
                check("write_data", o_writeData, pdata);
                wr_log.push_back(o_writeAddr);
            end
            if (fin) break;
            xfer = i_valid && exp_ready;
            @(posedge i_fire);
            pend = xfer;
            if (xfer) begin
                paddr = mptr; pdata = i_data; mptr = mptr + 8'd1; acc++;
                if (acc == n) fin = 1;
            end
            #1;
            cyc++;
            if (cyc > 4000) begin
                check("job_timeout", 1'b1, 1'b0);
                break;
            end
        end
        i_start = 1'b0;
        check("filled_at_done", o_filled, 72'(n));
        @(posedge i_fire); #1;
        i_valid = 1'b0; i_rd_req = 1'b0;
        @(negedge i_fire);
        check("idle_done", o_done, 1'b0);
        check("idle_busy", o_busy, 1'b0);
        check("idle_write_en", o_write_en, 1'b0);
        check("idle_ready", o_ready, 1'b0);
        check("filled_hold", o_filled, 72'(n));
    endtask

    typedef struct {
        logic [7:0] base;
        logic [8:0] cnt;
        int         vmode;
        int         rmode;
        bit         poke;
        int         exp_n;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] banks[4];

    initial begin
        tbl[0] = '{8'h10, 9'd4,   0, 0, 0, 4,   8'h10, 8'h13};
        tbl[1] = '{8'hFE, 9'd4,   0, 0, 0, 4,   8'hFE, 8'h01};
        tbl[2] = '{8'h30, 9'd6,   0, 1, 0, 6,   8'h30, 8'h35};
        tbl[3] = '{8'h00, 9'd0,   0, 0, 0, 0,   8'h00, 8'h00};
        tbl[4] = '{8'h40, 9'd300, 0, 0, 0, 256, 8'h40, 8'h3F};
        tbl[5] = '{8'h80, 9'd5,   1, 0, 1, 5,   8'h80, 8'h84};
        banks[0] = 8'd6; banks[1] = 8'd7; banks[2] = 8'd0; banks[3] = 8'd1;

        rst = 1'b0; i_start = 1'b0; i_baseAddr = '0; i_count = '0;
        i_valid = 1'b0; i_data = '0; i_rd_req = 1'b0;
        #12;
        check("rst_write_en", o_write_en, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_addr", o_writeAddr, 8'h0);
        check("rst_data", o_writeData, 72'h0);
        check("rst_filled", o_filled, 9'h0);
        check("rst_ready", o_ready, 1'b0);
        @(posedge i_fire); #1;
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_job(tbl[v].base, tbl[v].cnt, tbl[v].vmode, tbl[v].rmode, tbl[v].poke);
            check("tbl_nwrites", 72'(wr_log.size()), 72'(tbl[v].exp_n));
            check("tbl_filled", o_filled, 72'(tbl[v].exp_n));
            if (tbl[v].exp_n > 0) begin
                check("tbl_first", wr_log[0], tbl[v].exp_first);
                check("tbl_last", wr_log[wr_log.size()-1], tbl[v].exp_last);
            end
            if (v == 1) begin
                for (int k = 0; k < 4; k++)
                    check("wrap_bank", 72'(wr_log[k] % 8), banks[k]);
            end
        end

        // Reset in the middle of an 8-word job, with a write on the SRAM.
        i_start = 1'b1; i_baseAddr = 8'h50; i_count = 9'd8; i_valid = 1'b1; i_data = rnd_word();
        @(posedge i_fire); #1;
        i_start = 1'b0;
        @(posedge i_fire); #1;
        i_data = rnd_word();
        @(posedge i_fire); #1;
        check("pre_rst_write_en", o_write_en, 1'b1);
        check("pre_rst_filled", o_filled, 9'd2);
        rst = 1'b0;
        #1;
        check("midrst_write_en", o_write_en, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_filled", o_filled, 9'd0);
        check("midrst_ready", o_ready, 1'b0);
        i_valid = 1'b0;
        @(posedge i_fire); #1;
        rst = 1'b1;
        @(negedge i_fire);
        check("post_rst_idle", o_busy, 1'b0);
        @(posedge i_fire); #1;
        run_job(8'h20, 9'd3, 0, 0, 0);
        check("post_rst_first", wr_log[0], 8'h20);

        // Randomized jobs against the reference.
        for (int j = 0; j < 8; j++) begin
            logic [8:0] c;
            c = (j == 3) ? 9'd400 : 9'($urandom_range(0, 40));
            run_job(8'($urandom), c, 2, 2, j[0]);
            check("rand_nwrites", 72'(wr_log.size()), 72'((c > 9'd256) ? 256 : int'(c)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
